// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between execution units / decode and the register-file write arbiter.
// Requesters and decode drive through the master modport; the arbiter uses the slave modport.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsv_valid;
  logic [ADDR_W-1:0]         rsv_addr;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [31:0]               busy;

  modport master (
    output req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    input  req_ready, wr_en, wr_addr, wr_data, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, rsv_valid, rsv_addr,
    output req_ready, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter plus destination-register busy scoreboard for the regfile write port.
// Optional build macro R0_DISCARD_EN: transfers to r0 complete the handshake but never raise wr_en.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input logic                  clock,
  input logic                  reset_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [31:0]        busy_q, busy_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic               found_s;
  logic               xfer_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [31:0]        set_mask_s;
  logic [31:0]        clr_mask_s;

  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return PTR_W'(s);
  endfunction

  // Round-robin search from ptr, then mux out the winning slice and compute next state.
  always_comb begin
    grant_s    = '0;
    gnt_idx_s  = '0;
    found_s    = 1'b0;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && bus.req_valid[rr_idx(ptr_q, k)]) begin
        grant_s[rr_idx(ptr_q, k)] = 1'b1;
        gnt_idx_s                 = rr_idx(ptr_q, k);
        found_s                   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    // Reset blocks every grant so nothing is accepted while the port is held in reset.
    ready_s = reset_n ? grant_s : '0;
    xfer_s  = |ready_s;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_addr_s = sel_addr_s | ({ADDR_W{ready_s[k]}} & bus.req_addr[k*ADDR_W +: ADDR_W]);
      sel_data_s = sel_data_s | ({DATA_W{ready_s[k]}} & bus.req_data[k*DATA_W +: DATA_W]);
    end

    ptr_d = xfer_s ? ((gnt_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + 1'b1) : ptr_q;

`ifdef R0_DISCARD_EN
    wr_en_d = xfer_s && (sel_addr_s != '0);
`else
    wr_en_d = xfer_s;
`endif
    wr_addr_d = wr_en_d ? sel_addr_s : wr_addr_q;
    wr_data_d = wr_en_d ? sel_data_s : wr_data_q;

    // Set is applied after clear so a same-cycle reservation wins; bit 0 is forced low.
    clr_mask_s = xfer_s ? (32'd1 << sel_addr_s) : 32'd0;
    set_mask_s = bus.rsv_valid ? (32'd1 << bus.rsv_addr) : 32'd0;
    busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 32'd0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter: expected writes are queued by the stimulus
// and a negedge monitor pops and compares them whenever wr_en is seen high.
module tb_regfile_wb_arbiter;
  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;
  wr_t  exp_q[$];

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed write must match the oldest expected write.
  always @(negedge clock) begin
    if (bus.wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%08h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
          failures++;
          $display("FAIL write_port: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                   bus.wr_addr, bus.wr_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    checks        = 0;
    failures      = 0;
    reset_n       = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_addr  = 5'd0;
    set_req(0, 5'd1, 32'hAAAA_0001);
    set_req(1, 5'd2, 32'hBBBB_0002);
    set_req(2, 5'd3, 32'hCCCC_0003);

    // Reset held two cycles with all requesters valid.
    tick();
    tick();
    chk("reset_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
    chk("reset_busy", bus.busy, 32'd0);
    chk("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("reset_wr_data", bus.wr_data, 32'd0);

    // Round-robin with all valid: grants 0,1,2,0 and continuous wr_en.
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_ready", 32'(bus.req_ready), 32'd1 << (k % 3));
      push(5'((k % 3) + 1), (k % 3 == 0) ? 32'hAAAA_0001 : (k % 3 == 1) ? 32'hBBBB_0002 : 32'hCCCC_0003);
      tick();
      chk("rr_wr_en", 32'(bus.wr_en), 32'd1);
    end
    bus.req_valid = 3'b000;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("idle_wr_en", 32'(bus.wr_en), 32'd0);

    // Only requester 2 valid (ptr is 1 here): granted immediately, one-cycle write pulse.
    set_req(2, 5'd7, 32'hDEAD_BEEF);
    bus.req_valid = 3'b100;
    #1;
    chk("hold_ready", 32'(bus.req_ready), 32'b100);
    push(5'd7, 32'hDEAD_BEEF);
    tick();
    bus.req_valid = 3'b000;
    chk("hold_wr_en", 32'(bus.wr_en), 32'd1);
    tick();
    chk("hold_wr_en_off", 32'(bus.wr_en), 32'd0);
    chk("hold_wr_addr", 32'(bus.wr_addr), 32'd7);

    // Scoreboard: reserve r5, then clear it with a write from requester 0.
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd5;
    tick();
    bus.rsv_valid = 1'b0;
    chk("sb_set", bus.busy, 32'h0000_0020);
    tick();
    tick();
    set_req(0, 5'd5, 32'h0000_0055);
    bus.req_valid = 3'b001;
    #1;
    chk("sb_clr_ready", 32'(bus.req_ready), 32'b001);
    push(5'd5, 32'h0000_0055);
    tick();
    bus.req_valid = 3'b000;
    chk("sb_clr", bus.busy, 32'd0);
    chk("sb_clr_wr_en", 32'(bus.wr_en), 32'd1);

    // Same-cycle reserve and write to r5: the reservation wins.
    set_req(1, 5'd5, 32'h0000_0066);
    bus.req_valid = 3'b010;
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd5;
    #1;
    chk("sb_same_ready", 32'(bus.req_ready), 32'b010);
    push(5'd5, 32'h0000_0066);
    tick();
    bus.req_valid = 3'b000;
    bus.rsv_valid = 1'b0;
    chk("sb_set_wins", bus.busy, 32'h0000_0020);

    // Reserve r9 while r5 is written: both take effect.
    set_req(2, 5'd5, 32'h0000_0077);
    bus.req_valid = 3'b100;
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd9;
    #1;
    chk("sb_diff_ready", 32'(bus.req_ready), 32'b100);
    push(5'd5, 32'h0000_0077);
    tick();
    bus.req_valid = 3'b000;
    bus.rsv_valid = 1'b0;
    chk("sb_diff", bus.busy, 32'h0000_0200);

    // r0: reservation ignored; write behaviour depends on the build.
    bus.rsv_valid = 1'b1;
    bus.rsv_addr  = 5'd0;
    tick();
    bus.rsv_valid = 1'b0;
    chk("r0_rsv", bus.busy, 32'h0000_0200);
    set_req(0, 5'd0, 32'h0000_0099);
    bus.req_valid = 3'b001;
    #1;
    chk("r0_ready", 32'(bus.req_ready), 32'b001);
`ifndef R0_DISCARD_EN
    push(5'd0, 32'h0000_0099);
`endif
    tick();
    bus.req_valid = 3'b000;
`ifdef R0_DISCARD_EN
    chk("r0_wr_en", 32'(bus.wr_en), 32'd0);
    chk("r0_hold_addr", 32'(bus.wr_addr), 32'd5);
    chk("r0_hold_data", bus.wr_data, 32'h0000_0077);
`else
    chk("r0_wr_en", 32'(bus.wr_en), 32'd1);
    chk("r0_wr_addr", 32'(bus.wr_addr), 32'd0);
`endif
    chk("r0_busy", bus.busy, 32'h0000_0200);

    // Clear r9 via requester 1, then reserve r4..r7.
    set_req(1, 5'd9, 32'h0000_0009);
    bus.req_valid = 3'b010;
    #1;
    chk("pre_rst_ready", 32'(bus.req_ready), 32'b010);
    push(5'd9, 32'h0000_0009);
    tick();
    bus.req_valid = 3'b000;
    chk("pre_rst_clr", bus.busy, 32'd0);
    for (int r = 4; r < 8; r++) begin
      bus.rsv_valid = 1'b1;
      bus.rsv_addr  = 5'(r);
      tick();
    end
    bus.rsv_valid = 1'b0;
    chk("pre_rst_busy", bus.busy, 32'h0000_00F0);

    // Mid-run reset with a pending request from requester 2 (ptr is 2): grant is dropped.
    set_req(2, 5'd4, 32'h0000_0088);
    bus.req_valid = 3'b100;
    reset_n       = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("rst_mid_busy", bus.busy, 32'd0);
    chk("rst_mid_wr_en", 32'(bus.wr_en), 32'd0);
    reset_n = 1'b1;
    set_req(0, 5'd1, 32'hAAAA_0001);
    set_req(1, 5'd2, 32'hBBBB_0002);
    set_req(2, 5'd3, 32'hCCCC_0003);
    bus.req_valid = 3'b111;
    #1;
    chk("rst_ptr_zero", 32'(bus.req_ready), 32'b001);
    push(5'd1, 32'hAAAA_0001);
    tick();
    bus.req_valid = 3'b000;
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the single write port of the 32 x 32 register file. It accepts write-back requests from several execution units (ALU, load unit, multiply/divide) over valid/ready handshakes. Each cycle it grants one request round-robin and drives a registered write port, which the register file samples on the following falling edge. It also keeps a 32-bit busy bitmap of destination registers with outstanding writes, which decode uses for stall decisions.

## Interface
- NUM_REQ, 3, number of write-back requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous reset, active-low
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*ADDR_W  destination register; requester i occupies slice i
- req_data  in  NUM_REQ*DATA_W  write data; requester i occupies slice i
- req_ready  out  NUM_REQ  one-hot grant, combinational
- rsv_valid  in  1  decode reserves a destination register at issue
- rsv_addr  in  ADDR_W  register being reserved
- wr_en  out  1  write strobe to register file, registered
- wr_addr  out  ADDR_W  write address, registered
- wr_data  out  DATA_W  write data, registered
- busy  out  32  scoreboard; bit k=1 means register k has a pending write

## Operation
- Arbitration: round-robin pointer `ptr`. The search starts at `ptr` and wraps through NUM_REQ-1 back to 0. The first index with req_valid=1 gets req_ready=1. All other ready lines are 0.
- A transfer occurs when req_valid[i] & req_ready[i] are both 1. After a transfer, ptr becomes (i+1) mod NUM_REQ. With no transfer, ptr holds.
- A requester must keep valid, addr and data stable until its transfer. Deasserting valid without a transfer is illegal and is not checked.
- Write port: on a transfer, the next edge loads wr_addr and wr_data from the granted slice and sets wr_en=1. With no transfer, wr_en=0 and wr_addr/wr_data hold their last values.
- Scoreboard: rsv_valid=1 sets busy[rsv_addr] at the edge.
  - A transfer to address a clears busy[a] at the same edge that raises wr_en.
  - If a set and a clear hit the same register in one cycle, the set wins.
  - Sets and clears to different registers both take effect.
- Register 0: busy[0] is always 0. Reservations to address 0 are ignored.
- The arbiter does not check whether a transfer matches an earlier reservation. A write to a non-busy register is committed normally, and busy stays 0.
- During reset (reset_n=0), req_ready is forced to 0 so that no transfers occur.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, ptr=0, req_ready=0.
- Latency: a transfer in cycle N gives wr_en=1 in cycle N+1. The register file commits on the negedge of cycle N+1.
- Throughput: one write per cycle. Back-to-back transfers give a continuous run of wr_en.
- req_ready depends combinationally on req_valid and ptr only, never on wr_en.
- Reset mid-operation: in-flight grants are lost, wr_en drops at the reset edge, and busy clears. Requesters must reissue after reset.
- A requester that holds valid is granted within NUM_REQ cycles.

## Configuration
- R0_DISCARD_EN defined: a transfer addressed to register 0 completes its handshake normally, but wr_en stays 0 and wr_addr/wr_data hold. The register file never sees a write to r0.
- R0_DISCARD_EN undefined: transfers to register 0 drive wr_en=1 like any other address. The register file is then responsible for r0 behaviour.
- busy[0]=0 in both builds.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, wr_en=0, busy=0. On release, requester 0 is granted first.
- Round-robin: NUM_REQ=3, all valid continuously, addresses 1/2/3 with data A/B/C -> grants 0,1,2,0,...; wr_en stays high from the cycle after release; wr_addr sequence 1,2,3,1.
- Handshake hold: only requester 2 valid (addr 7, data 0xDEADBEEF) -> req_ready=3'b100 in the same cycle; next cycle wr_en=1, wr_addr=7, wr_data=0xDEADBEEF; the cycle after, wr_en=0.
- Scoreboard: rsv to r5 in cycle 0 -> busy[5]=1 in cycle 1. A transfer to r5 in cycle 3 -> busy[5]=0 and wr_en=1 in cycle 4. A rsv to r5 in the same cycle as a transfer to r5 -> busy[5] stays 1.
- r0: rsv to r0 leaves busy=0. A transfer to r0 -> with R0_DISCARD_EN, wr_en=0; without it, wr_en=1 and wr_addr=0.
- Mid-run reset: busy=0x000000F0 with a transfer pending, then reset_n=0 for 1 cycle -> busy=0, wr_en=0, and ptr restarts at 0.
